mem_stage: RTL and testbench

//  Memory-access pipeline stage between exe_stage and wb_stage of the LoongArch core.

---
 rtl/mem_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EXE and WB.
// Holds one EXE payload, waits for the data response on loads and stores that
// were accepted on the bus in EXE, extends load data and hands the result to WB.
// Responses that belong to instructions removed by a flush are counted so that
// their late data_ok beats can be recognised and dropped.
module mem_stage #(
  parameter int CANCEL_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic        es_rf_we,
  input  logic [4:0]  es_rf_waddr,
  input  logic [31:0] es_result,
  input  logic        es_res_from_mem,
  input  logic        es_mem_req,
  input  logic [4:0]  es_ld_type,
  input  logic        es_excp,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  input  logic        flush,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic        ms_rf_we,
  output logic [4:0]  ms_rf_waddr,
  output logic [31:0] ms_final_result,
  output logic        ms_excp,
  output logic        ms_to_es_excp,
  output logic        ms_fwd_blocked
);

  localparam logic [CANCEL_W-1:0] CANCEL_MAX = '1;
  localparam logic [CANCEL_W-1:0] CANCEL_ONE = CANCEL_W'(1);

  logic                ms_valid;
  logic                ms_ready_go;
  logic                load_en;
  logic                live_ok;
  logic                buf_capture;
  logic                buf_valid;
  logic [31:0]         buf_data;
  logic                cancel_inc;
  logic                cancel_dec;
  logic [CANCEL_W-1:0] cancel_cnt;

  logic                rf_we_q;
  logic [31:0]         ms_result;
  logic                ms_res_from_mem;
  logic                ms_mem_req;
  logic [4:0]          ms_ld_type;

  logic [31:0]         rd;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_ext;

  // A data_ok beat is ours only once every orphaned response has drained.
  assign live_ok     = data_sram_data_ok && (cancel_cnt == '0);
  assign ms_ready_go = !ms_mem_req || buf_valid || live_ok;
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
  assign load_en     = es_to_ms_valid && ms_allowin && !flush;

  // Response arrived but WB is not taking the payload yet: park the data.
  assign buf_capture = live_ok && ms_valid && ms_mem_req && !ms_allowin;

  // A pending request whose response has not come back becomes an orphan on flush.
  assign cancel_inc  = flush && ms_valid && ms_mem_req && !buf_valid && !live_ok;
  assign cancel_dec  = data_sram_data_ok && (cancel_cnt != '0);

  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms_rf_we       = rf_we_q && ms_valid;
  assign ms_to_es_excp  = ms_valid && ms_excp;
  assign ms_fwd_blocked = ms_valid && ms_res_from_mem && !ms_ready_go;

  // Stage occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Payload registers, loaded when a new instruction enters the stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_pc           <= '0;
      rf_we_q         <= 1'b0;
      ms_rf_waddr     <= '0;
      ms_result       <= '0;
      ms_res_from_mem <= 1'b0;
      ms_mem_req      <= 1'b0;
      ms_ld_type      <= '0;
      ms_excp         <= 1'b0;
    end else if (load_en) begin
      ms_pc           <= es_pc;
      rf_we_q         <= es_rf_we;
      ms_rf_waddr     <= es_rf_waddr;
      ms_result       <= es_result;
      ms_res_from_mem <= es_res_from_mem;
      ms_mem_req      <= es_mem_req;
      ms_ld_type      <= es_ld_type;
      ms_excp         <= es_excp;
    end
  end

  // Response buffer, valid until the payload leaves or is flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (flush || ms_allowin) begin
      buf_valid <= 1'b0;
    end else if (buf_capture) begin
      buf_valid <= 1'b1;
      buf_data  <= data_sram_rdata;
    end
  end

  // Orphaned-response counter; an increment and a stale drain cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      cancel_cnt <= '0;
    end else begin
      case ({cancel_inc, cancel_dec})
        2'b10:   cancel_cnt <= cancel_cnt + CANCEL_ONE;
        2'b01:   cancel_cnt <= cancel_cnt - CANCEL_ONE;
        default: cancel_cnt <= cancel_cnt;
      endcase
    end
  end

  // More orphans than the counter can hold would misattribute a later response.
  assert property (@(posedge clk) disable iff (reset)
    !(cancel_inc && !cancel_dec && (cancel_cnt == CANCEL_MAX)));

  // Load data selection and sign/zero extension by byte offset.
  always_comb begin
    rd = buf_valid ? buf_data : data_sram_rdata;
    case (ms_result[1:0])
      2'd0:    ld_byte = rd[7:0];
      2'd1:    ld_byte = rd[15:8];
      2'd2:    ld_byte = rd[23:16];
      default: ld_byte = rd[31:24];
    endcase
    ld_half = ms_result[1] ? rd[31:16] : rd[15:0];
    ld_ext  = rd;
    if (ms_ld_type[4])      ld_ext = {{24{ld_byte[7]}}, ld_byte};
    else if (ms_ld_type[3]) ld_ext = {24'b0, ld_byte};
    else if (ms_ld_type[2]) ld_ext = {{16{ld_half[15]}}, ld_half};
    else if (ms_ld_type[1]) ld_ext = {16'b0, ld_half};
    ms_final_result = ms_res_from_mem ? ld_ext : ms_result;
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage. The bench plays EXE, WB and the
// data bus; each instruction is described by when its response and WB release
// happen, and the expected outputs follow from those event times.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [31:0] es_result;
  logic        es_res_from_mem;
  logic        es_mem_req;
  logic [4:0]  es_ld_type;
  logic        es_excp;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        flush;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_final_result;
  logic        ms_excp;
  logic        ms_to_es_excp;
  logic        ms_fwd_blocked;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr),
    .es_result(es_result), .es_res_from_mem(es_res_from_mem),
    .es_mem_req(es_mem_req), .es_ld_type(es_ld_type), .es_excp(es_excp),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_allowin(ws_allowin), .flush(flush),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_rf_we(ms_rf_we),
    .ms_rf_waddr(ms_rf_waddr), .ms_final_result(ms_final_result),
    .ms_excp(ms_excp), .ms_to_es_excp(ms_to_es_excp),
    .ms_fwd_blocked(ms_fwd_blocked)
  );

  always #5 clk = ~clk;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_EXCP = 3;
  localparam logic [4:0] LD_B = 5'b10000, LD_BU = 5'b01000, LD_H = 5'b00100,
                         LD_HU = 5'b00010, LD_W = 5'b00001;

  int n_cmp = 0;
  int n_bad = 0;
  int orphans = 0;   // responses owed by the bus to instructions already flushed
  int stalls;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [4:0] ldt, input logic [1:0] off,
                                           input logic [31:0] data);
    logic [31:0] b, h;
    b = (data >> (8 * off)) & 32'hFF;
    h = (data >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (ldt)
      LD_B:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      LD_BU:   return b;
      LD_H:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      LD_HU:   return h;
      default: return data;
    endcase
  endfunction

  task automatic drive_idle();
    es_to_ms_valid    = 1'b0;
    es_pc             = $urandom;
    es_rf_we          = 1'($urandom_range(0, 1));
    es_rf_waddr       = 5'($urandom_range(0, 31));
    es_result         = $urandom;
    es_res_from_mem   = 1'($urandom_range(0, 1));
    es_mem_req        = 1'($urandom_range(0, 1));
    es_ld_type        = 5'($urandom_range(0, 31));
    es_excp           = 1'($urandom_range(0, 1));
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom;
    ws_allowin        = 1'b1;
    flush             = 1'b0;
  endtask

  // One instruction through MEM. ok_delay: cycles after the stale beats until its
  // own response; hold: cycles WB refuses after it is ready; flush_c: cycle of a
  // flush (-1 or beyond release means none).
  task automatic run_op(input int kind, input logic [4:0] ldt, input logic [1:0] off,
                        input logic [31:0] data, input int ok_delay, input int hold,
                        input int flush_c, output int n_stall);
    logic [31:0] pc, res, exp_res;
    logic        we, mem, ld, ex;
    logic [4:0]  wa;
    int          n_stale, ready_c, rel_c, waited;
    mem = (kind == K_LOAD) || (kind == K_STORE);
    ld  = (kind == K_LOAD);
    ex  = (kind == K_EXCP);
    pc  = $urandom;
    res = $urandom;
    if (mem) res[1:0] = off;
    we  = 1'($urandom_range(0, 1));
    wa  = 5'($urandom_range(0, 31));
    exp_res = ld ? ref_load(ldt, off, data) : res;
    n_stale = mem ? orphans : 0;
    ready_c = mem ? n_stale + ok_delay : 0;
    rel_c   = ready_c + hold;
    n_stall = 0;

    waited = 0;
    while (!ms_allowin && waited < 10) begin
      @(posedge clk); #1; drive_idle(); #1;
      waited++;
    end
    check_val("allowin_before_issue", ms_allowin, 1'b1);
    es_to_ms_valid  = 1'b1;
    es_pc           = pc;
    es_rf_we        = we;
    es_rf_waddr     = wa;
    es_result       = res;
    es_res_from_mem = ld;
    es_mem_req      = mem;
    es_ld_type      = ld ? ldt : 5'd0;
    es_excp         = ex;
    @(posedge clk); #1;

    for (int c = 0; c <= rel_c; c++) begin
      drive_idle();
      data_sram_data_ok = (c < n_stale) || (mem && c == ready_c);
      if (mem && c == ready_c) data_sram_rdata = data;
      ws_allowin = (c >= rel_c);
      flush      = (c == flush_c);
      #1;
      if (c < n_stale) orphans--;
      if (c == flush_c) begin
        if (mem && c < ready_c) orphans++;
        @(posedge clk); #1; drive_idle(); #1;
        check_val("flushed_no_wb_valid", ms_to_ws_valid, 1'b0);
        check_val("flushed_allowin", ms_allowin, 1'b1);
        check_val("flushed_to_es_excp", ms_to_es_excp, 1'b0);
        check_val("cancel_cnt_after_flush", 32'(dut.cancel_cnt), orphans);
        return;
      end
      check_val("to_ws_valid", ms_to_ws_valid, (c >= ready_c));
      check_val("fwd_blocked", ms_fwd_blocked, (ld && c < ready_c));
      check_val("to_es_excp", ms_to_es_excp, ex);
      if (ms_fwd_blocked) n_stall++;
      if (c == rel_c) begin
        check_val("final_result", ms_final_result, exp_res);
        check_val("pc", ms_pc, pc);
        check_val("rf_we", ms_rf_we, we);
        check_val("rf_waddr", ms_rf_waddr, wa);
        check_val("excp", ms_excp, ex);
      end
      @(posedge clk); #1;
    end
    drive_idle(); #1;
    check_val("left_stage", ms_to_ws_valid, 1'b0);
    check_val("cancel_cnt", 32'(dut.cancel_cnt), orphans);
  endtask

  initial begin
    int kind, ok_d, hold, fc;
    logic [4:0] ldt;
    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_val("rst_allowin", ms_allowin, 1'b1);
    check_val("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
    check_val("rst_pc", ms_pc, 32'd0);
    check_val("rst_rf_we", ms_rf_we, 1'b0);
    check_val("rst_waddr", ms_rf_waddr, 5'd0);
    check_val("rst_result", ms_final_result, 32'd0);
    check_val("rst_excp", ms_excp, 1'b0);
    check_val("rst_to_es_excp", ms_to_es_excp, 1'b0);
    check_val("rst_fwd_blocked", ms_fwd_blocked, 1'b0);

    // Plain ALU op, one cycle.
    run_op(K_ALU, 5'd0, 2'd0, 32'd0, 0, 0, -1, stalls);
    // ld_b at offset 3, response three cycles later.
    run_op(K_LOAD, LD_B, 2'd3, 32'h80AA_BBCC, 3, 0, -1, stalls);
    check_val("ld_b_stall_cycles", stalls, 3);
    // ld_hu at offset 2, response buffered while WB stalls.
    run_op(K_LOAD, LD_HU, 2'd2, 32'h80AA_BBCC, 0, 2, -1, stalls);
    // Flush a pending ld_w, then the stale beat must be dropped.
    run_op(K_LOAD, LD_W, 2'd0, 32'h0000_1234, 3, 0, 1, stalls);
    check_val("orphan_counted", 32'(dut.cancel_cnt), 1);
    run_op(K_LOAD, LD_W, 2'd0, 32'hCAFE_F00D, 2, 0, -1, stalls);
    // Flush in the same cycle as the response.
    run_op(K_LOAD, LD_H, 2'd2, 32'h8001_7FFF, 2, 1, 2, stalls);
    run_op(K_LOAD, LD_H, 2'd0, 32'h1234_9ABC, 1, 0, -1, stalls);
    // Exception-carrying instruction.
    run_op(K_EXCP, 5'd0, 2'd0, 32'd0, 0, 1, -1, stalls);
    run_op(K_STORE, 5'd0, 2'd1, 32'd0, 2, 1, -1, stalls);

    // Reset while an orphan is outstanding and a load is waiting.
    run_op(K_LOAD, LD_W, 2'd0, 32'd0, 4, 0, 0, stalls);
    es_to_ms_valid  = 1'b1;
    es_mem_req      = 1'b1;
    es_res_from_mem = 1'b1;
    es_ld_type      = LD_W;
    @(posedge clk); #1; drive_idle(); #1;
    check_val("pre_reset_blocked", ms_fwd_blocked, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; #1;
    orphans = 0;
    check_val("mid_rst_to_ws_valid", ms_to_ws_valid, 1'b0);
    check_val("mid_rst_fwd_blocked", ms_fwd_blocked, 1'b0);
    check_val("mid_rst_allowin", ms_allowin, 1'b1);
    check_val("mid_rst_pc", ms_pc, 32'd0);
    check_val("mid_rst_cancel", 32'(dut.cancel_cnt), 0);

    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 3);
      ldt  = 5'(1 << $urandom_range(0, 4));
      ok_d = $urandom_range(0, 4);
      hold = $urandom_range(0, 3);
      fc   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, ok_d + hold + 1) : -1;
      run_op(kind, ldt, 2'($urandom_range(0, 3)), $urandom, ok_d, hold, fc, stalls);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
